// File: rtl/sspm_backbone.sv
// sspm_backbone: TDM round-robin responder serving NCORES SSPM connectors from one single-ported word memory.
// Optional slot locking is enabled by defining SSPM_SLOT_LOCK_EN.
module sspm_backbone #(
   parameter int NCORES     = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LOCK_MAX   = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic [NCORES-1:0]              io_select,
   input  logic [NCORES*DATA_WIDTH-1:0]   io_data_out,
   input  logic [NCORES*ADDR_WIDTH-1:0]   io_addr,
   input  logic [NCORES-1:0]              io_we,
   output logic [DATA_WIDTH-1:0]          io_data_in,
   input  logic [NCORES-1:0]              io_lock,
   output logic [$clog2(NCORES)-1:0]      io_slot
);
   localparam int SW    = $clog2(NCORES);
   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
   logic [SW-1:0]           slot, slot_adv;
   logic [ADDR_WIDTH-3:0]   word;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    we, stay;
   logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
   assign word      = io_addr[slot*ADDR_WIDTH+2 +: ADDR_WIDTH-2];
   assign wdata     = io_data_out[slot*DATA_WIDTH +: DATA_WIDTH];
   assign we        = io_we[slot];
   assign io_select = NCORES'(1) << slot;
   assign io_slot   = slot;
   assign slot_adv  = (slot == SW'(NCORES - 1)) ? '0 : slot + 1'b1;
`ifdef SSPM_SLOT_LOCK_EN
   localparam int HW = $clog2(LOCK_MAX + 1);
   logic [HW-1:0] hold;
   assign stay = io_lock[slot] && (hold < HW'(LOCK_MAX - 1));
   always_ff @(posedge clk) begin
      if (reset) hold <= '0;
      else hold <= stay ? hold + 1'b1 : '0;
   end
`else
   logic unused_lock;
   assign unused_lock = ^io_lock ^ LOCK_MAX[0];
   assign stay = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         slot       <= '0;
         io_data_in <= '0;
      end else begin
         slot       <= stay ? slot : slot_adv;
         io_data_in <= mem[word];
      end
   end
   // read-before-write: the read above samples the old word in the same edge
   always_ff @(posedge clk) begin
      if (!reset && we) mem[word] <= wdata;
   end
endmodule

// File: tb/tb_sspm_backbone.sv
// tb_sspm_backbone: scoreboard bench; stimulus pushes expected select/slot/read data, a monitor pops and compares.
module tb_sspm_backbone;
   localparam int NC = 4, AW = 16, DW = 32, LM = 8;
   logic clk = 1'b0, reset = 1'b1;
   logic [NC-1:0]    io_select, io_we = '0, io_lock = '0;
   logic [NC*DW-1:0] io_data_out = '0;
   logic [NC*AW-1:0] io_addr = '0;
   logic [DW-1:0]    io_data_in;
   logic [1:0]       io_slot;
   typedef struct {
      logic [NC-1:0] sel;
      int            slot;
      bit            known;
      logic [DW-1:0] rd;
   } exp_t;
   exp_t           q[$];
   logic [DW-1:0]  mem_m[int];
   int             mslot = 0, mhold = 0;
   int             vectors = 0, miscompares = 0;
   bit             done = 0;
   sspm_backbone #(.NCORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset), .io_select(io_select), .io_data_out(io_data_out),
      .io_addr(io_addr), .io_we(io_we), .io_data_in(io_data_in), .io_lock(io_lock), .io_slot(io_slot)
   );
   always #5 clk = ~clk;
   // one cycle: the granted core gets the given access, every other core drives write noise
   task automatic cyc(input bit r, input bit we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] lk);
      exp_t e;
      int w;
      @(negedge clk);
      reset = r;
      io_lock = lk;
      for (int i = 0; i < NC; i++) begin
         io_we[i] = (i == mslot) ? we : 1'b1;
         io_addr[i*AW +: AW] = (i == mslot) ? a : 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         io_data_out[i*DW +: DW] = (i == mslot) ? d : $urandom;
      end
      e.sel = 4'b0001 << mslot;
      e.slot = mslot;
      if (r) begin
         e.known = 1;
         e.rd = '0;
         mslot = 0;
         mhold = 0;
      end else begin
         w = int'(a) / 4;
         e.known = mem_m.exists(w);
         e.rd = e.known ? mem_m[w] : '0;
         if (we) mem_m[w] = d;
`ifdef SSPM_SLOT_LOCK_EN
         if (lk[mslot] && mhold < LM - 1) mhold++;
         else begin mhold = 0; mslot = (mslot + 1) % NC; end
`else
         mslot = (mslot + 1) % NC;
`endif
      end
      q.push_back(e);
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("select", 32'(io_select), 32'(e.sel));
            chk("slot", 32'(io_slot), 32'(e.slot));
            @(posedge clk);
            #1;
            if (e.known) chk("data_in", io_data_in, e.rd);
         end
      end
   end
   initial begin : stim
      repeat (3) cyc(1, 1, 16'h0010, 32'h0BAD0BAD, 4'b0);
      cyc(0, 0, 16'h0010, 0, 0);
      cyc(0, 0, 16'h0000, 0, 0);
      cyc(0, 1, 16'h0010, 32'hDEADBEEF, 0);
      cyc(0, 0, 16'h0004, 0, 0);
      cyc(0, 0, 16'h0008, 0, 0);
      cyc(0, 0, 16'h0010, 0, 0);
      cyc(0, 0, 16'h0013, 0, 0);
      cyc(0, 1, 16'h0040, 32'h12345678, 0);
      cyc(0, 1, 16'h0040, 32'hCAFEF00D, 0);
      cyc(0, 0, 16'h0040, 0, 0);
      cyc(0, 1, 16'h0020, 32'h5A5A5A5A, 0);
      cyc(0, 0, 16'h0044, 0, 0);
      cyc(0, 0, 16'h0048, 0, 0);
      cyc(0, 0, 16'h004C, 0, 0);
      cyc(1, 1, 16'h0020, 32'hAAAA5555, 0);
      cyc(0, 0, 16'h0020, 0, 0);
      cyc(0, 0, 16'h0010, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 16'h0040, 0, 4'b1010);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 49) == 0, 1'($urandom), 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
             $urandom, 4'($urandom));
      repeat (3) @(posedge clk);
      #2;
      done = 1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
